// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// controller states and the mult/div latency constant.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Edges from the accepting edge to the edge that writes HI/LO.
    function automatic int unsigned mdu_latency(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. acc holds the upper half / partial remainder, mq the lower half.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mq_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc} + (mq[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        rem_sh = {acc, mq[WIDTH-1]};
        diff   = rem_sh - {1'b0, opd};
        if (is_div) begin
            // A clear top bit of diff means the trial subtraction fits.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                mq_next  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_sh[WIDTH-1:0];
                mq_next  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = sum[WIDTH:1];
            mq_next  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential MIPS-style multiply/divide unit with HI/LO registers.
// Define MDU_SEQ_CANCEL_EN to add the cancel port for aborting an operation.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_SEQ_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned LATENCY = mdu_latency(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    logic cancel_w;
`ifdef MDU_SEQ_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    mdu_state_e       state_reg, state_next;
    logic             armed_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] acc_reg, mq_reg, opd_reg, a_raw_reg;
    logic             is_div_reg, neg_q_reg, neg_r_reg, div0_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic             accept, accept_md, last_iter;
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_acc, step_mq;
    logic [2*WIDTH-1:0] prod_abs, prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    // armed_reg blocks a start sampled on the edge that releases reset.
    assign accept    = armed_reg && start && !cancel_w && (state_reg == ST_IDLE);
    assign accept_md = accept && !op[2];
    assign last_iter = (cnt_reg == CW'(LATENCY - 2));

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .mq       (mq_reg),
        .opd      (opd_reg),
        .acc_next (step_acc),
        .mq_next  (step_mq)
    );

    assign prod_abs = {acc_reg, mq_reg};
    assign prod_fix = neg_q_reg ? -prod_abs : prod_abs;

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (div0_reg) begin
                fix_hi = a_raw_reg;
                fix_lo = '1;
            end else begin
                fix_lo = neg_q_reg ? -mq_reg : mq_reg;
                fix_hi = neg_r_reg ? -acc_reg : acc_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept_md) state_next = ST_CALC;
            ST_CALC: begin
                if (cancel_w)       state_next = ST_IDLE;
                else if (last_iter) state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_reg  <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mq_reg     <= '0;
            opd_reg    <= '0;
            a_raw_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            armed_reg <= 1'b1;
            done_reg  <= 1'b0;
            // Both ops load |a| into mq and |b| into opd; the product is symmetric.
            if (accept_md) begin
                cnt_reg    <= '0;
                acc_reg    <= '0;
                mq_reg     <= a_mag;
                opd_reg    <= b_mag;
                a_raw_reg  <= a;
                is_div_reg <= op[1];
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                div0_reg   <= op[1] && (b == '0);
            end else if (state_reg == ST_CALC) begin
                acc_reg <= step_acc;
                mq_reg  <= step_mq;
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (state_reg == ST_FIX && !cancel_w) begin
                hi_reg   <= fix_hi;
                lo_reg   <= fix_lo;
                done_reg <= 1'b1;
            end else if (accept && op == OP_MTHI) begin
                hi_reg <= a;
            end else if (accept && op == OP_MTLO) begin
                lo_reg <= a;
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
